// File: rtl/mesi_snoop_bus_pkg.sv
// Shared types and helpers for the MESI snoop-bus coherence controller.
//   mesi_t       : per-line coherence state, encoded I=00 S=01 E=10 M=11
//   fsm_t        : controller sequencing states
//   idx_of       : directory set index of an address
//   tag_of       : directory tag of an address (caller truncates to TAG_W)
//   state_to_str : printable name of a MESI state, for benches
package mesi_snoop_bus_pkg;

    typedef enum logic [1:0] {
        I = 2'b00,
        S = 2'b01,
        E = 2'b10,
        M = 2'b11
    } mesi_t;

    typedef enum logic [1:0] {
        IDLE,
        SNOOP,
        UPDATE
    } fsm_t;

    // sets must be a power of two, so masking selects the index field.
    function automatic int unsigned idx_of(input logic [63:0] a,
                                           input int unsigned line_off,
                                           input int unsigned sets);
        return 32'((a >> line_off) & 64'(sets - 1));
    endfunction

    function automatic logic [63:0] tag_of(input logic [63:0] a,
                                           input int unsigned line_off,
                                           input int unsigned idx_w);
        return a >> (line_off + idx_w);
    endfunction

    function automatic string state_to_str(input mesi_t s);
        case (s)
            I:       return "I";
            S:       return "S";
            E:       return "E";
            default: return "M";
        endcase
    endfunction

endpackage

// File: rtl/mesi_snoop_bus_if.sv
// Cache-side bus of the coherence controller.
//   read_req/write_req : per-cache requests, held until req_ack
//   addr[N]            : per-cache request address, stable while pending
//   req_ack            : one-cycle completion pulse to the granted cache
//   mem_read/mem_write : one-cycle memory fill / writeback pulses per cache
//   state[N]           : MESI state of the line currently addressed by addr[i]
//   busy               : controller is processing a transaction
// master = cache side (drives requests), slave = controller.
interface mesi_snoop_bus_if
    import mesi_snoop_bus_pkg::*;
#(
    parameter int N      = 2,
    parameter int ADDR_W = 32
) ();

    logic [N-1:0]      read_req;
    logic [N-1:0]      write_req;
    logic [ADDR_W-1:0] addr [N];
    logic [N-1:0]      req_ack;
    logic [N-1:0]      mem_read;
    logic [N-1:0]      mem_write;
    mesi_t             state [N];
    logic              busy;

    modport master (
        output read_req, write_req, addr,
        input  req_ack, mem_read, mem_write, state, busy
    );

    modport slave (
        input  read_req, write_req, addr,
        output req_ack, mem_read, mem_write, state, busy
    );

endinterface

// File: rtl/mesi_snoop_bus_rr_arbiter.sv
// Round-robin arbiter, purely combinational.
//   req       : request vector
//   ptr       : highest-priority position this round
//   grant     : one-hot grant of the first requester at or after ptr (wrapping)
//   grant_idx : binary index of the granted requester
//   valid     : at least one request present
module mesi_snoop_bus_rr_arbiter #(
    parameter  int N     = 2,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             valid
);

    int j;

    // NOTE: every output gets a default before the search so no path
    // leaves a value held over, which would infer a latch.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!valid && req[j]) begin
                valid     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/mesi_snoop_bus.sv
// N-cache MESI coherence controller with direct-mapped per-cache directories.
// Requests are granted round-robin, snooped against peer directories, and the
// resulting fill/writeback pulses and state changes are applied in one cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : cache-side request/response bundle (slave modport)
module mesi_snoop_bus
    import mesi_snoop_bus_pkg::*;
#(
    parameter int N        = 2,
    parameter int ADDR_W   = 32,
    parameter int LINE_OFF = 4,
    parameter int SETS     = 4
) (
    input logic             clk,
    input logic             rst,
    mesi_snoop_bus_if.slave bus
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - LINE_OFF - IDX_W;
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [TAG_W-1:0] dir_tag [N][SETS];
    mesi_t            dir_st  [N][SETS];

    fsm_t             fsm_q, fsm_d;
    logic [PTR_W-1:0] rr_ptr, win_q;
    logic [N-1:0]     win_oh_q;
    logic             op_wr_q;
    logic [IDX_W-1:0] idx_q;
    logic [TAG_W-1:0] tag_q;

    // Snoop results, registered in SNOOP and consumed in UPDATE.
    mesi_t            own_q;
    logic             victim_m_q;
    logic [N-1:0]     peer_valid_q;
    logic [N-1:0]     owner_oh_q;

    logic [IDX_W-1:0] req_idx [N];
    logic [TAG_W-1:0] req_tag [N];
    logic [N-1:0]     grant_oh;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_valid;
    logic             inv_ok;

    mesi_snoop_bus_rr_arbiter #(.N(N)) u_arb (
        .req       (bus.read_req | bus.write_req),
        .ptr       (rr_ptr),
        .grant     (grant_oh),
        .grant_idx (grant_idx),
        .valid     (grant_valid)
    );

    // Per-cache address decode and state lookup; a tag mismatch reads as I.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_idx[i]   = IDX_W'(idx_of(64'(bus.addr[i]), LINE_OFF, SETS));
            req_tag[i]   = TAG_W'(tag_of(64'(bus.addr[i]), LINE_OFF, IDX_W));
            bus.state[i] = (dir_tag[i][req_idx[i]] == req_tag[i])
                         ? dir_st[i][req_idx[i]] : I;
        end
    end

    // Next state and the single-cycle UPDATE pulses.
    always_comb begin
        fsm_d         = fsm_q;
        bus.req_ack   = '0;
        bus.mem_read  = '0;
        bus.mem_write = '0;
        bus.busy      = (fsm_q != IDLE);
        case (fsm_q)
            IDLE:   if (grant_valid) fsm_d = SNOOP;
            SNOOP:  fsm_d = UPDATE;
            UPDATE: begin
                fsm_d       = IDLE;
                bus.req_ack = win_oh_q;
                if (own_q == I) begin
                    // Writes always fetch (RFO); reads fetch only if no peer holds the line.
                    if (op_wr_q || (peer_valid_q == '0))
                        bus.mem_read = win_oh_q;
                    bus.mem_write = owner_oh_q | (victim_m_q ? win_oh_q : '0);
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q        <= IDLE;
            rr_ptr       <= '0;
            win_q        <= '0;
            win_oh_q     <= '0;
            op_wr_q      <= 1'b0;
            idx_q        <= '0;
            tag_q        <= '0;
            own_q        <= I;
            victim_m_q   <= 1'b0;
            peer_valid_q <= '0;
            owner_oh_q   <= '0;
            // NOTE: the directory is a small register array, not RAM; it must
            // be cleared so every line starts invalid after reset.
            for (int i = 0; i < N; i++) begin
                for (int s = 0; s < SETS; s++) begin
                    dir_tag[i][s] <= '0;
                    dir_st[i][s]  <= I;
                end
            end
        end else begin
            fsm_q <= fsm_d;
            case (fsm_q)
                IDLE: if (grant_valid) begin
                    win_q    <= grant_idx;
                    win_oh_q <= grant_oh;
                    op_wr_q  <= bus.write_req[grant_idx];
                    idx_q    <= req_idx[grant_idx];
                    tag_q    <= req_tag[grant_idx];
                end
                SNOOP: begin
                    own_q      <= (dir_tag[win_q][idx_q] == tag_q) ? dir_st[win_q][idx_q] : I;
                    victim_m_q <= (dir_tag[win_q][idx_q] != tag_q) && (dir_st[win_q][idx_q] == M);
                    for (int j = 0; j < N; j++) begin
                        peer_valid_q[j] <= (j != int'(win_q)) && (dir_tag[j][idx_q] == tag_q)
                                        && (dir_st[j][idx_q] != I);
                        owner_oh_q[j]   <= (j != int'(win_q)) && (dir_tag[j][idx_q] == tag_q)
                                        && (dir_st[j][idx_q] == M);
                    end
                end
                UPDATE: begin
                    if (!op_wr_q) begin
                        if (own_q == I) begin
                            // Miss: the requester's entry is (re)allocated, evicting any victim.
                            dir_tag[win_q][idx_q] <= tag_q;
                            if (owner_oh_q != '0) begin
                                dir_st[win_q][idx_q] <= S;
                                for (int j = 0; j < N; j++)
                                    if (owner_oh_q[j]) dir_st[j][idx_q] <= S;
                            end else if (peer_valid_q != '0) begin
                                dir_st[win_q][idx_q] <= S;
                                for (int j = 0; j < N; j++)
                                    if (peer_valid_q[j] && dir_st[j][idx_q] == E) dir_st[j][idx_q] <= S;
                            end else begin
                                dir_st[win_q][idx_q] <= E;
                            end
                        end
                    end else if (own_q != M) begin
                        // E has no peers, so one path covers E, S and I.
                        dir_tag[win_q][idx_q] <= tag_q;
                        dir_st[win_q][idx_q]  <= M;
                        for (int j = 0; j < N; j++)
                            if (peer_valid_q[j]) dir_st[j][idx_q] <= I;
                    end
                    rr_ptr <= (int'(win_q) == N - 1) ? '0 : win_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Coherence invariant: per line, an M or E copy is the only valid copy.
    always_comb begin
        inv_ok = 1'b1;
        for (int s = 0; s < SETS; s++)
            for (int a = 0; a < N; a++)
                for (int b = a + 1; b < N; b++)
                    if (dir_tag[a][s] == dir_tag[b][s] && dir_st[a][s] != I && dir_st[b][s] != I
                        && (dir_st[a][s][1] || dir_st[b][s][1]))
                        inv_ok = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (inv_ok);
    end

endmodule

// File: tb/tb_mesi_snoop_bus.sv
// Self-checking bench for mesi_snoop_bus: directed coherence scenarios followed
// by randomized request rounds, all compared against a line-level MESI model.
module tb_mesi_snoop_bus;
    import mesi_snoop_bus_pkg::*;

    localparam int N        = 2;
    localparam int ADDR_W   = 32;
    localparam int LINE_OFF = 4;
    localparam int SETS     = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mesi_snoop_bus_if #(.N(N), .ADDR_W(ADDR_W)) bus ();

    mesi_snoop_bus #(.N(N), .ADDR_W(ADDR_W), .LINE_OFF(LINE_OFF), .SETS(SETS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [ADDR_W-1:0] tb_addr [N];
    logic [N-1:0]      last_mr, last_mw;

    // Reference model: per cache and set, which full line address is held and
    // its MESI state (0=I 1=S 2=E 3=M).
    logic [63:0] m_line [N][SETS];
    int          m_st   [N][SETS];
    int          m_ptr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int set_of(input logic [63:0] a);
        return int'((a >> LINE_OFF) % SETS);
    endfunction

    function automatic int mstate(input int c, input logic [63:0] a);
        if (m_line[c][set_of(a)] == (a >> LINE_OFF)) return m_st[c][set_of(a)];
        return 0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++)
            for (int s = 0; s < SETS; s++) begin
                m_line[c][s] = '0;
                m_st[c][s]   = 0;
            end
        m_ptr = 0;
    endtask

    task automatic model_txn(input int c, input bit wr, input logic [63:0] a,
                             output logic [N-1:0] mr, output logic [N-1:0] mw);
        int own, st, owner;
        bit anyp;
        logic [63:0] line;
        st    = set_of(a);
        line  = a >> LINE_OFF;
        own   = mstate(c, a);
        owner = -1;
        anyp  = 1'b0;
        mr    = '0;
        mw    = '0;
        for (int j = 0; j < N; j++)
            if (j != c && mstate(j, a) != 0) begin
                anyp = 1'b1;
                if (mstate(j, a) == 3) owner = j;
            end
        if (own == 0 && m_st[c][st] == 3) mw[c] = 1'b1;   // dirty victim evicted
        if (!wr) begin
            if (own == 0) begin
                m_line[c][st] = line;
                if (owner >= 0) begin
                    mw[owner] = 1'b1;
                    m_st[owner][st] = 1;
                    m_st[c][st] = 1;
                end else if (anyp) begin
                    m_st[c][st] = 1;
                    for (int j = 0; j < N; j++)
                        if (j != c && mstate(j, a) == 2) m_st[j][st] = 1;
                end else begin
                    mr[c] = 1'b1;
                    m_st[c][st] = 2;
                end
            end
        end else if (own != 3) begin
            if (own == 0) begin
                mr[c] = 1'b1;
                if (owner >= 0) mw[owner] = 1'b1;
            end
            for (int j = 0; j < N; j++)
                if (j != c && mstate(j, a) != 0) m_st[j][st] = 0;
            m_line[c][st] = line;
            m_st[c][st]   = 3;
        end
    endtask

    // Called at a negedge in IDLE with requests already driven; serves all
    // pending requests in model round-robin order.
    task automatic serve(input string name);
        logic [N-1:0] pend, mr, mw;
        int w, lat;
        pend = bus.read_req | bus.write_req;
        while (pend != '0) begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (bus.req_ack == '0 && lat < 10);
            check({name, " ack_latency"}, 64'(lat), 64'd2);
            check({name, " req_ack"}, 64'(bus.req_ack), 64'(1) << w);
            check({name, " busy_in_update"}, 64'(bus.busy), 64'd1);
            model_txn(w, bus.write_req[w], 64'(tb_addr[w]), mr, mw);
            check({name, " mem_read"}, 64'(bus.mem_read), 64'(mr));
            check({name, " mem_write"}, 64'(bus.mem_write), 64'(mw));
            last_mr = bus.mem_read;
            last_mw = bus.mem_write;
            bus.read_req[w]  = 1'b0;
            bus.write_req[w] = 1'b0;
            pend[w] = 1'b0;
            m_ptr   = (w + 1) % N;
            @(negedge clk);
            check({name, " busy_idle"}, 64'(bus.busy), 64'd0);
            for (int i = 0; i < N; i++)
                check({name, " state"}, 64'(bus.state[i]), 64'(mstate(i, 64'(tb_addr[i]))));
        end
    endtask

    task automatic request(input logic [N-1:0] rdv, input logic [N-1:0] wrv, input string name);
        bus.read_req  = rdv;
        bus.write_req = wrv;
        serve(name);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.read_req  = '0;
        bus.write_req = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.read_req  = '0;
        bus.write_req = '0;
        for (int i = 0; i < N; i++) begin
            tb_addr[i]  = 32'h1000;
            bus.addr[i] = tb_addr[i];
        end
        model_reset();
        repeat (3) @(negedge clk);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset req_ack", 64'(bus.req_ack), 64'd0);
        check("reset mem_read", 64'(bus.mem_read), 64'd0);
        check("reset mem_write", 64'(bus.mem_write), 64'd0);
        check("reset state0", 64'(bus.state[0]), 64'(I));
        check("reset state1", 64'(bus.state[1]), 64'(I));
        rst = 1'b0;
        @(negedge clk);

        // Read miss with no sharers -> fill, Exclusive.
        request(2'b01, 2'b00, "c0_rd");
        check("c0_rd mr", 64'(last_mr), 64'h1);
        check("c0_rd mw", 64'(last_mw), 64'h0);
        check("c0_rd st0", 64'(bus.state[0]), 64'(E));
        check("c0_rd st1", 64'(bus.state[1]), 64'(I));

        // Read miss with clean peer -> both Shared, no memory traffic.
        request(2'b10, 2'b00, "c1_rd");
        check("c1_rd mr", 64'(last_mr), 64'h0);
        check("c1_rd st0", 64'(bus.state[0]), 64'(S));
        check("c1_rd st1", 64'(bus.state[1]), 64'(S));

        // Write hit in S -> upgrade, peer invalidated, no memory traffic.
        request(2'b00, 2'b10, "c1_wr");
        check("c1_wr mr", 64'(last_mr), 64'h0);
        check("c1_wr mw", 64'(last_mw), 64'h0);
        check("c1_wr st1", 64'(bus.state[1]), 64'(M));
        check("c1_wr st0", 64'(bus.state[0]), 64'(I));

        // Read miss against dirty peer -> peer flushes, both Shared.
        request(2'b01, 2'b00, "c0_rd_dirty");
        check("c0_rd_dirty mw", 64'(last_mw), 64'h2);
        check("c0_rd_dirty mr", 64'(last_mr), 64'h0);
        check("c0_rd_dirty st0", 64'(bus.state[0]), 64'(S));

        // c0 takes M, then a conflicting write evicts the dirty line.
        request(2'b00, 2'b01, "c0_wr_up");
        check("c0_wr_up st0", 64'(bus.state[0]), 64'(M));
        tb_addr[0]  = 32'h1040;
        bus.addr[0] = tb_addr[0];
        request(2'b00, 2'b01, "c0_evict");
        check("c0_evict mw", 64'(last_mw), 64'h1);
        check("c0_evict mr", 64'(last_mr), 64'h1);
        check("c0_evict st0", 64'(bus.state[0]), 64'(M));
        tb_addr[0]  = 32'h1000;
        bus.addr[0] = tb_addr[0];
        #1;
        check("c0_evict old_line", 64'(bus.state[0]), 64'(I));

        // Round-robin: simultaneous requests from reset, then rotation.
        do_reset();
        tb_addr[0] = 32'h2000; bus.addr[0] = tb_addr[0];
        tb_addr[1] = 32'h3010; bus.addr[1] = tb_addr[1];
        request(2'b11, 2'b00, "rr_both_a");
        request(2'b11, 2'b00, "rr_both_b");
        request(2'b01, 2'b00, "rr_c0_only");
        request(2'b11, 2'b00, "rr_ptr1");

        // Reset during SNOOP drops the transaction.
        tb_addr[0] = 32'h5000; bus.addr[0] = tb_addr[0];
        bus.read_req = 2'b01;
        @(negedge clk);
        check("midrst busy_snoop", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst busy", 64'(bus.busy), 64'd0);
        check("midrst ack", 64'(bus.req_ack), 64'd0);
        bus.read_req = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("midrst no_ack", 64'(bus.req_ack), 64'd0);
        end
        tb_addr[0] = 32'h2000; bus.addr[0] = tb_addr[0];
        #1;
        check("midrst st0", 64'(bus.state[0]), 64'(I));
        check("midrst st1", 64'(bus.state[1]), 64'(I));

        // Randomized rounds over a small conflicting address pool.
        for (int r = 0; r < 80; r++) begin
            logic [N-1:0] rdv, wrv;
            rdv = '0;
            wrv = '0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) != 0) begin
                    if ($urandom_range(0, 1) != 0) wrv[i] = 1'b1;
                    else rdv[i] = 1'b1;
                    if ($urandom_range(0, 7) == 0) rdv[i] = 1'b1;
                    tb_addr[i] = 32'(32'h1000 + ($urandom_range(0, 2) << 6)
                               + ($urandom_range(0, 1) << 4) + $urandom_range(0, 15));
                    bus.addr[i] = tb_addr[i];
                end
            end
            if ((rdv | wrv) == '0) rdv[0] = 1'b1;
            request(rdv, wrv, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
